// File: rtl/counter_cmd_sequencer_pkg.sv
// Shared types for the counter command sequencer: opcodes, FSM states,
// requester ids and the opcode-to-strobe mapping.
package counter_seq_pkg;

    typedef enum logic [2:0] {
        OP_RESET  = 3'd0,
        OP_SET    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_INC_N  = 3'd3,
        OP_DEC_N  = 3'd4,
        OP_SHL_IN = 3'd5,
        OP_SHR_IN = 3'd6,
        OP_RSVD   = 3'd7
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int STB_W = 7;

    // Strobe bit i belongs to opcode i: Reset, Set, Load, Inc, Dec, ShiftR2L, ShiftL2R.
    function automatic logic [STB_W-1:0] op_strobe(op_t op);
        logic [STB_W-1:0] stb;
        stb = '0;
        if (op != OP_RSVD) stb = STB_W'(1) << op;
        return stb;
    endfunction

endpackage

// File: rtl/counter_cmd_sequencer_if.sv
// Request channels from both requesters plus the strobe/data bus toward the counter.
interface counter_cmd_sequencer_if #(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 32
);
    logic              ReqValidA, ReqValidB;
    logic              ReqReadyA, ReqReadyB;
    logic [2:0]        ReqOpA, ReqOpB;
    logic [DATA_W-1:0] ReqArgA, ReqArgB;
    logic [CNT_W-1:0]  ReqCountA, ReqCountB;
    logic              Abort;
    logic              DoReset, DoSet, DoLoad, DoIncrement, DoDecrement;
    logic              DoShiftL2R, DoShiftR2L;
    logic [DATA_W-1:0] CounterInData;
    logic              CounterInMSB, CounterInLSB;
    logic              Busy, Done, DoneId, DoneAborted;

    modport master (
        output ReqValidA, ReqValidB, ReqOpA, ReqOpB, ReqArgA, ReqArgB,
               ReqCountA, ReqCountB, Abort,
        input  ReqReadyA, ReqReadyB, DoReset, DoSet, DoLoad, DoIncrement,
               DoDecrement, DoShiftL2R, DoShiftR2L, CounterInData,
               CounterInMSB, CounterInLSB, Busy, Done, DoneId, DoneAborted
    );

    modport slave (
        input  ReqValidA, ReqValidB, ReqOpA, ReqOpB, ReqArgA, ReqArgB,
               ReqCountA, ReqCountB, Abort,
        output ReqReadyA, ReqReadyB, DoReset, DoSet, DoLoad, DoIncrement,
               DoDecrement, DoShiftL2R, DoShiftR2L, CounterInData,
               CounterInMSB, CounterInLSB, Busy, Done, DoneId, DoneAborted
    );
endinterface

// File: rtl/counter_cmd_sequencer_rr_arbiter2.sv
// Two-requester round-robin grant; the pointer flips to the loser on every accept.
module rr_arbiter2
    import counter_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic valid_a,
    input  logic valid_b,
    output logic ready_a,
    output logic ready_b,
    output logic grant_id,
    output logic accept
);
    logic ptr_q, ptr_d;

    always_comb begin
        grant_id = (valid_a && valid_b) ? ptr_q : (valid_b ? REQ_B : REQ_A);
        ready_a  = en && valid_a && (grant_id == REQ_A);
        ready_b  = en && valid_b && (grant_id == REQ_B);
        accept   = ready_a || ready_b;
        ptr_d    = accept ? ~grant_id : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= REQ_A;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/counter_cmd_sequencer.sv
// Accepts commands from two requesters and expands each into registered
// one-hot strobes for the multi-function counter.
//
//  state | meaning
//  IDLE  | waiting for a request; ReqReady offered to the granted side
//  EXEC  | emitting strobes for the latched command; Done on the last one
module counter_cmd_sequencer
    import counter_seq_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 32
) (
    input logic Clock,
    input logic nReset,
    counter_cmd_sequencer_if.slave bus
);
    localparam int IDX_W  = $clog2(DATA_W);
    localparam int BIDX_W = IDX_W + 1;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [DATA_W-1:0]  arg_q, arg_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [BIDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic               id_q, id_d;
    logic [STB_W-1:0]   strb_q, strb_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               msb_q, msb_d, lsb_q, lsb_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               done_id_q, done_id_d, aborted_q, aborted_d;

    logic               ready_a, ready_b, grant_id, accept;
    op_t                sel_op;
    logic [DATA_W-1:0]  sel_arg;
    logic [CNT_W-1:0]   sel_cnt, clamp_cnt, n_strobes;

    rr_arbiter2 u_arb (
        .clk      (Clock),
        .rst_n    (nReset),
        .en       ((state_q == IDLE) && nReset),
        .valid_a  (bus.ReqValidA),
        .valid_b  (bus.ReqValidB),
        .ready_a  (ready_a),
        .ready_b  (ready_b),
        .grant_id (grant_id),
        .accept   (accept)
    );

    always_comb begin
        sel_op    = (grant_id == REQ_B) ? op_t'(bus.ReqOpB) : op_t'(bus.ReqOpA);
        sel_arg   = (grant_id == REQ_B) ? bus.ReqArgB : bus.ReqArgA;
        sel_cnt   = (grant_id == REQ_B) ? bus.ReqCountB : bus.ReqCountA;
        clamp_cnt = (int'(sel_cnt) > DATA_W) ? CNT_W'(DATA_W) : sel_cnt;
        case (sel_op)
            OP_RESET, OP_SET, OP_LOAD: n_strobes = CNT_W'(1);
            OP_INC_N, OP_DEC_N:        n_strobes = sel_cnt;
            OP_SHL_IN, OP_SHR_IN:      n_strobes = clamp_cnt;
            default:                   n_strobes = '0;
        endcase
    end

    // rem_q counts strobes still owed after the one currently on the outputs;
    // for SHL_IN that same value is the index of the bit being shifted in.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        arg_d     = arg_q;
        rem_d     = rem_q;
        bit_idx_d = bit_idx_q;
        id_d      = id_q;
        strb_d    = '0;
        data_d    = '0;
        msb_d     = 1'b0;
        lsb_d     = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = EXEC;
                    op_d      = sel_op;
                    arg_d     = sel_arg;
                    id_d      = grant_id;
                    busy_d    = 1'b1;
                    bit_idx_d = BIDX_W'(1);
                    rem_d     = (n_strobes == '0) ? '0 : n_strobes - CNT_W'(1);
                    done_d    = (n_strobes <= CNT_W'(1));
                    if (done_d) done_id_d = grant_id;
                    if (n_strobes != '0) begin
                        strb_d = op_strobe(sel_op);
                        if (sel_op == OP_LOAD)   data_d = sel_arg;
                        if (sel_op == OP_SHL_IN) lsb_d  = sel_arg[IDX_W'(n_strobes - CNT_W'(1))];
                        if (sel_op == OP_SHR_IN) msb_d  = sel_arg[0];
                    end
                end
            end
            EXEC: begin
                if (done_q) begin
                    state_d = IDLE;
                end else if (bus.Abort) begin
                    busy_d    = 1'b1;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    done_id_d = id_q;
                end else begin
                    busy_d = 1'b1;
                    strb_d = op_strobe(op_q);
                    rem_d  = rem_q - CNT_W'(1);
                    done_d = (rem_q == CNT_W'(1));
                    if (done_d) done_id_d = id_q;
                    if (op_q == OP_SHL_IN) lsb_d = arg_q[IDX_W'(rem_q - CNT_W'(1))];
                    if (op_q == OP_SHR_IN) msb_d = arg_q[bit_idx_q[IDX_W-1:0]];
                    if (bit_idx_q != BIDX_W'(DATA_W)) bit_idx_d = bit_idx_q + BIDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            op_q      <= OP_RESET;
            arg_q     <= '0;
            rem_q     <= '0;
            bit_idx_q <= '0;
            id_q      <= REQ_A;
            strb_q    <= '0;
            data_q    <= '0;
            msb_q     <= 1'b0;
            lsb_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            rem_q     <= rem_d;
            bit_idx_q <= bit_idx_d;
            id_q      <= id_d;
            strb_q    <= strb_d;
            data_q    <= data_d;
            msb_q     <= msb_d;
            lsb_q     <= lsb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.ReqReadyA     = ready_a;
    assign bus.ReqReadyB     = ready_b;
    assign bus.DoReset       = strb_q[0];
    assign bus.DoSet         = strb_q[1];
    assign bus.DoLoad        = strb_q[2];
    assign bus.DoIncrement   = strb_q[3];
    assign bus.DoDecrement   = strb_q[4];
    assign bus.DoShiftR2L    = strb_q[5];
    assign bus.DoShiftL2R    = strb_q[6];
    assign bus.CounterInData = data_q;
    assign bus.CounterInMSB  = msb_q;
    assign bus.CounterInLSB  = lsb_q;
    assign bus.Busy          = busy_q;
    assign bus.Done          = done_q;
    assign bus.DoneId        = done_id_q;
    assign bus.DoneAborted   = aborted_q;
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer: arbitration, strobe timing,
// serial bit order, abort and mid-command reset.
module tb_counter_cmd_sequencer;
    import counter_seq_pkg::*;

    localparam int CNT_W  = 8;
    localparam int DATA_W = 32;

    logic Clock  = 1'b0;
    logic nReset = 1'b1;
    int   tests  = 0;
    int   fails  = 0;

    always #5 Clock = ~Clock;

    counter_cmd_sequencer_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

    counter_cmd_sequencer #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    wire [6:0] strb = {bus.DoShiftL2R, bus.DoShiftR2L, bus.DoDecrement,
                       bus.DoIncrement, bus.DoLoad, bus.DoSet, bus.DoReset};

    always @(negedge Clock) begin
        if (nReset === 1'b1) begin
            tests++;
            if ($countones(strb) > 1) begin
                fails++;
                $display("FAIL onehot: strobes %b at %0t, required at most one high", strb, $time);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ReqValidA = 0; bus.ReqValidB = 0; bus.Abort = 0;
        bus.ReqOpA = '0; bus.ReqOpB = '0; bus.ReqArgA = '0; bus.ReqArgB = '0;
        bus.ReqCountA = '0; bus.ReqCountB = '0;
    endtask

    task automatic drive(input bit side, input logic [2:0] op,
                         input logic [DATA_W-1:0] arg, input logic [CNT_W-1:0] cnt);
        if (!side) begin
            bus.ReqValidA = 1; bus.ReqOpA = op; bus.ReqArgA = arg; bus.ReqCountA = cnt;
        end else begin
            bus.ReqValidB = 1; bus.ReqOpB = op; bus.ReqArgB = arg; bus.ReqCountB = cnt;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 nReset = 0;
        bus.ReqValidA = 1;
        #2;
        tests++;
        if ({bus.ReqReadyA, bus.Busy, bus.Done, strb, bus.CounterInData} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b strb=%b data=%h, required all 0",
                     bus.ReqReadyA, bus.Busy, bus.Done, strb, bus.CounterInData);
        end
        repeat (2) @(posedge Clock);
        #1 nReset = 1;
        bus.ReqValidA = 0;
        tick();
    endtask

    task automatic test_arbitration();
        drive(0, 3'd4, '0, 8'd2);
        drive(1, 3'd4, '0, 8'd2);
        #1;
        tests++;
        if ({bus.ReqReadyA, bus.ReqReadyB} !== 2'b10) begin
            fails++; $display("FAIL arb_first: readyA/B=%b%b required 10", bus.ReqReadyA, bus.ReqReadyB);
        end
        tick(); bus.ReqValidA = 0;
        #1;
        tests++;
        if ({bus.DoDecrement, bus.ReqReadyB, bus.Busy} !== 3'b101) begin
            fails++; $display("FAIL arb_exec1: dec/readyB/busy=%b%b%b required 101",
                              bus.DoDecrement, bus.ReqReadyB, bus.Busy);
        end
        tick();
        tests++;
        if ({bus.DoDecrement, bus.Done, bus.DoneId, bus.ReqReadyB} !== 4'b1100) begin
            fails++; $display("FAIL arb_doneA: dec/done/id/readyB=%b%b%b%b required 1100",
                              bus.DoDecrement, bus.Done, bus.DoneId, bus.ReqReadyB);
        end
        tick();
        tests++;
        if ({bus.ReqReadyB, strb} !== {1'b1, 7'b0}) begin
            fails++; $display("FAIL arb_acceptB: readyB=%b strb=%b required 1 0000000", bus.ReqReadyB, strb);
        end
        tick(); bus.ReqValidB = 0;
        tick();
        tests++;
        if ({bus.DoDecrement, bus.Done, bus.DoneId} !== 3'b111) begin
            fails++; $display("FAIL arb_doneB: dec/done/id=%b%b%b required 111",
                              bus.DoDecrement, bus.Done, bus.DoneId);
        end
        tick();
        drive(0, 3'd4, '0, 8'd2);
        drive(1, 3'd4, '0, 8'd2);
        #1;
        tests++;
        if ({bus.ReqReadyA, bus.ReqReadyB} !== 2'b10) begin
            fails++; $display("FAIL arb_return: readyA/B=%b%b required 10", bus.ReqReadyA, bus.ReqReadyB);
        end
        idle_inputs();
    endtask

    task automatic test_load();
        tick();
        drive(0, 3'd2, 32'hDEADBEEF, 8'd0);
        #1;
        tests++;
        if ({bus.ReqReadyA, bus.ReqReadyB} !== 2'b10) begin
            fails++; $display("FAIL load_ready: readyA/B=%b%b required 10", bus.ReqReadyA, bus.ReqReadyB);
        end
        tick(); idle_inputs();
        tests++;
        if ({strb, bus.CounterInData, bus.Done, bus.DoneId, bus.DoneAborted} !== {7'b0000100, 32'hDEADBEEF, 3'b100}) begin
            fails++; $display("FAIL load_strobe: strb=%b data=%h done=%b id=%b abt=%b required 0000100 deadbeef 1 0 0",
                              strb, bus.CounterInData, bus.Done, bus.DoneId, bus.DoneAborted);
        end
        tick();
        bus.ReqValidA = 1;
        #1;
        tests++;
        if ({bus.ReqReadyA, strb, bus.CounterInData} !== {1'b1, 39'b0}) begin
            fails++; $display("FAIL load_after: readyA=%b strb=%b data=%h required 1 0 0",
                              bus.ReqReadyA, strb, bus.CounterInData);
        end
        bus.ReqValidA = 0;
    endtask

    task automatic test_inc_n();
        int inc, other, first, last, done_at;
        inc = 0; other = 0; first = 0; last = 0; done_at = 0;
        tick();
        drive(0, 3'd3, '0, 8'd5);
        tick(); idle_inputs();
        for (int c = 1; c <= 7; c++) begin
            if (strb == 7'b0001000) begin
                inc++;
                if (first == 0) first = c;
                last = c;
            end else if (strb != 7'b0) other++;
            if (bus.Done) done_at = c;
            tick();
        end
        tests++;
        if ({inc, first, last, other, done_at} !== {32'd5, 32'd1, 32'd5, 32'd0, 32'd5}) begin
            fails++; $display("FAIL inc5: inc=%0d first=%0d last=%0d other=%0d done_at=%0d required 5 1 5 0 5",
                              inc, first, last, other, done_at);
        end
    endtask

    task automatic test_shift();
        logic [3:0]  lsb_exp;
        logic [31:0] arg;
        int n, mism, done_at;
        lsb_exp = 4'b1010;
        tick();
        drive(0, 3'd5, 32'hA, 8'd4);
        tick(); idle_inputs();
        for (int c = 0; c < 4; c++) begin
            tests++;
            if ({strb, bus.CounterInLSB, bus.CounterInMSB} !== {7'b0100000, lsb_exp[3-c], 1'b0}) begin
                fails++; $display("FAIL shl_bit%0d: strb=%b lsb=%b msb=%b required 0100000 %b 0",
                                  c, strb, bus.CounterInLSB, bus.CounterInMSB, lsb_exp[3-c]);
            end
            if (c == 3) begin
                tests++;
                if (bus.Done !== 1'b1) begin
                    fails++; $display("FAIL shl_done: done=%b required 1", bus.Done);
                end
            end
            tick();
        end
        tests++;
        if ({strb, bus.CounterInLSB} !== 8'b0) begin
            fails++; $display("FAIL shl_after: strb=%b lsb=%b required 0", strb, bus.CounterInLSB);
        end
        arg = 32'hC3A50F96;
        n = 0; mism = 0; done_at = -1;
        drive(1, 3'd6, arg, 8'd40);
        tick(); idle_inputs();
        for (int c = 0; c <= 40; c++) begin
            if (bus.DoShiftL2R) begin
                if (bus.CounterInMSB !== arg[c]) mism++;
                n++;
            end
            if (bus.Done) done_at = c;
            tick();
        end
        tests++;
        if ({n, mism, done_at} !== {32'd32, 32'd0, 32'd31}) begin
            fails++; $display("FAIL shr40: strobes=%0d bit_errors=%0d done_at=%0d required 32 0 31", n, mism, done_at);
        end
    endtask

    task automatic test_abort();
        int inc;
        inc = 0;
        tick();
        drive(0, 3'd3, '0, 8'd10);
        tick(); idle_inputs();
        for (int c = 1; c <= 7; c++) begin
            if (bus.DoIncrement) inc++;
            if (c == 4) begin
                tests++;
                if ({bus.Done, bus.DoneAborted, bus.Busy, strb} !== {3'b111, 7'b0}) begin
                    fails++; $display("FAIL abort_done: done=%b abt=%b busy=%b strb=%b required 1 1 1 0",
                                      bus.Done, bus.DoneAborted, bus.Busy, strb);
                end
            end
            if (c == 5) begin
                tests++;
                if ({bus.Busy, bus.Done} !== 2'b00) begin
                    fails++; $display("FAIL abort_idle: busy=%b done=%b required 0 0", bus.Busy, bus.Done);
                end
            end
            bus.Abort = (c == 3);
            tick();
        end
        tests++;
        if (inc !== 3) begin
            fails++; $display("FAIL abort_count: increments=%0d required 3", inc);
        end
        drive(0, 3'd3, '0, 8'd2);
        tick(); idle_inputs();
        tick();
        tests++;
        if ({bus.DoIncrement, bus.Done, bus.DoneAborted} !== 3'b110) begin
            fails++; $display("FAIL abort_last: inc=%b done=%b abt=%b required 1 1 0",
                              bus.DoIncrement, bus.Done, bus.DoneAborted);
        end
        bus.Abort = 1;
        tick();
        bus.Abort = 0;
        tests++;
        if ({bus.Done, bus.DoneAborted, bus.Busy, strb} !== 10'b0) begin
            fails++; $display("FAIL abort_last_after: done=%b abt=%b busy=%b strb=%b required 0",
                              bus.Done, bus.DoneAborted, bus.Busy, strb);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        tick();
        drive(1, 3'd4, '0, 8'd8);
        tick(); idle_inputs();
        tick();
        tick();
        nReset = 0;
        #1;
        tests++;
        if ({strb, bus.Busy, bus.Done} !== 9'b0) begin
            fails++; $display("FAIL rst_mid_out: strb=%b busy=%b done=%b required 0", strb, bus.Busy, bus.Done);
        end
        bus.ReqValidB = 1;
        #1;
        tests++;
        if (bus.ReqReadyB !== 1'b0) begin
            fails++; $display("FAIL rst_mid_ready: readyB=%b required 0", bus.ReqReadyB);
        end
        repeat (2) @(posedge Clock);
        #1 nReset = 1;
        bus.ReqValidB = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.Done || (strb != 7'b0)) seen++;
            tick();
        end
        tests++;
        if (seen !== 0) begin
            fails++; $display("FAIL rst_mid_nodone: activity_cycles=%0d required 0", seen);
        end
        drive(0, 3'd3, '0, 8'd0);
        drive(1, 3'd2, 32'h1234, 8'd0);
        #1;
        tests++;
        if ({bus.ReqReadyA, bus.ReqReadyB} !== 2'b10) begin
            fails++; $display("FAIL rst_ptr: readyA/B=%b%b required 10", bus.ReqReadyA, bus.ReqReadyB);
        end
        tick(); idle_inputs();
        tests++;
        if ({bus.Done, bus.DoneId, bus.Busy, strb} !== {3'b101, 7'b0}) begin
            fails++; $display("FAIL zero_inc: done=%b id=%b busy=%b strb=%b required 1 0 1 0",
                              bus.Done, bus.DoneId, bus.Busy, strb);
        end
        tick();
        tests++;
        if ({bus.Busy, bus.Done} !== 2'b00) begin
            fails++; $display("FAIL zero_inc_after: busy=%b done=%b required 0 0", bus.Busy, bus.Done);
        end
        drive(1, 3'd7, '0, 8'd9);
        tick(); idle_inputs();
        tests++;
        if ({bus.Done, bus.DoneId, bus.DoneAborted, strb} !== {3'b110, 7'b0}) begin
            fails++; $display("FAIL rsvd_op: done=%b id=%b abt=%b strb=%b required 1 1 0 0",
                              bus.Done, bus.DoneId, bus.DoneAborted, strb);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_load();
        test_inc_n();
        test_shift();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
- Sequences the 32-bit multi-function counter/shift register, which has one-hot Do* strobes, parallel data and serial MSB/LSB inputs.
- Two requesters (A, B) submit commands over valid/ready; a round-robin arbiter picks one at a time.
- Multi-cycle commands (increment/decrement by N, serial shift-in of N bits) become one strobe per cycle.
- Sits between control logic and the counter; it is the only driver of the counter's Do* inputs.

Parameters:
CNT_W, 8, width of the per-command repeat count
DATA_W, 32, counter data width; shift counts clamp to this

Ports:
Clock  in  1  system clock, rising edge
nReset  in  1  asynchronous, active-low reset
ReqValidA, ReqValidB  in  1 each  command valid per requester
ReqReadyA, ReqReadyB  out  1 each  command accepted when Valid & Ready
ReqOpA, ReqOpB  in  3 each  opcode
ReqArgA, ReqArgB  in  DATA_W each  load data / serial bit source
ReqCountA, ReqCountB  in  CNT_W each  repeat count
Abort  in  1  stop the current multi-cycle command
DoReset, DoSet, DoLoad, DoIncrement, DoDecrement, DoShiftL2R, DoShiftR2L  out  1 each  registered strobes to the counter
CounterInData  out  DATA_W  registered parallel data
CounterInMSB, CounterInLSB  out  1 each  registered serial bits
Busy  out  1  high while in EXEC
Done  out  1  one-cycle completion pulse
DoneId  out  1  0 = A, 1 = B; valid with Done
DoneAborted  out  1  command ended by Abort; valid with Done

Behaviour:
- Reset: nReset low forces all outputs to 0 immediately, state to IDLE and round-robin pointer to A.
  - A reset mid-command discards that command with no Done.
- Opcodes:
  - 0 RESET, 1 SET, 2 LOAD: single strobe; count ignored.
  - 3 INC_N, 4 DEC_N: Count strobes.
  - 5 SHL_IN: DoShiftR2L; CounterInLSB = Arg[k-1] down to Arg[0], where k = min(Count, DATA_W).
  - 6 SHR_IN: DoShiftL2R; CounterInMSB = Arg[0] up to Arg[k-1].
  - 7 reserved: no strobe, normal Done.
- States: IDLE, EXEC.
- IDLE:
  - ReqReady goes only to the granted requester, combinationally from the Valids and the pointer.
  - Grant rule: if only one requester is valid, it is granted. If both are valid, the pointer side is granted.
  - On acceptance (cycle T):
    - Latch op, arg, count and id.
    - Set the pointer to the other requester.
    - Go to EXEC.
- EXEC:
  - A command with N strobes (N ≥ 1) drives strobes in cycles T+1..T+N.
  - Done, DoneId and Busy are asserted in the cycle of the last strobe, which is T+N.
  - Next state is IDLE at T+N+1; a new acceptance is possible at T+N+1.
- Zero-length commands (count 0 for ops 3–6, and op 7) produce no strobe; Done is asserted at T+1.
- At most one Do* strobe is high in any cycle.
- CounterInData = latched Arg only during the LOAD strobe cycle; 0 otherwise.
- Serial bits are 0 outside shift cycles.
- Abort sampled high in EXEC, cycle t:
  - The strobe already driven in t completes.
  - No strobes from t+1 onward.
  - Done and DoneAborted pulse at t+1; state is IDLE at t+2.
  - Abort in IDLE is ignored.
  - If Abort arrives in the last-strobe cycle, normal Done is given and DoneAborted = 0.
- Remaining count is an internal down-counter of width CNT_W.
- Shift bit index is a separate counter that clamps at DATA_W.
- Requests held Valid while not Ready must keep op/arg/count stable; no other checks are made.
- ReqReady is 0 in EXEC and during reset.

Decomposition:
- Package counter_seq_pkg holds:
  - op_t enum (the 8 codes)
  - state_t {IDLE, EXEC}
  - the REQ_A/REQ_B id constants
- One sub-module, rr_arbiter2: a two-input round-robin grant with a pointer update on accept.
- Strobe generation and counters stay in the top module.

Test Plan:
- A LOAD Arg=0xDEADBEEF, B idle -> ReqReadyA at T, DoLoad=1 and CounterInData=0xDEADBEEF at T+1, Done with DoneId=0 at T+1, ReqReadyA possible again at T+2.
- A INC_N Count=5 -> DoIncrement high for exactly 5 cycles T+1..T+5, Done at T+5, no other strobe.
- A and B valid together, both DEC_N Count=2, after reset -> A is served first, then B accepted at T+3. Then A and B are valid again -> A is granted (pointer has returned to A).
- A SHL_IN Arg=0xA Count=4 -> DoShiftR2L for 4 cycles with CounterInLSB sequence 1,0,1,0. Separately, SHR_IN Count=40 -> exactly 32 strobes.
- A INC_N Count=10 with Abort pulsed in the 3rd strobe cycle -> exactly 3 DoIncrement, then Done=1 and DoneAborted=1 the next cycle.
- B DEC_N Count=8 with nReset asserted after the 2nd strobe -> all strobes 0 immediately and no Done. After release, A and B valid together -> A is granted. A Count=0 INC_N -> Done at T+1 with no strobe.
